gun_fire_controller: RTL and testbench

Converts the player's trigger into rate-limited projectile spawn requests and enforces an overheat lockout driven by the gun heat counter. Sits between the heat counter (consumes its 4-bit heat value) and the projectile spawner, which it drives over a req/ack handshake carrying the ship's X position at trigger time. Also exports a saturating shot count and an overheat flag for the HUD.

---
 rtl/gun_fire_controller.sv | 127 ++++++++++++
 tb/tb_gun_fire_controller.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gun_fire_controller.sv
// Trigger-to-spawn fire controller: rate-limited req/ack shots, heat lockout with hysteresis, shot count.
// Optional request timeout enabled by defining GUN_TIMEOUT_EN.
module gun_fire_controller #(
  parameter int HEAT_MAX    = 15,
  parameter int HEAT_RESUME = 8,
  parameter int FIRE_GAP    = 12_500_000,
  parameter int GAP_W       = 24
`ifdef GUN_TIMEOUT_EN
  , parameter int REQ_TIMEOUT = 1024
`endif
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       trigger,
  input  logic [3:0] heat,
  input  logic [7:0] ship_x,
  input  logic       fire_ack,
  output logic       fire_req,
  output logic [7:0] fire_x,
  output logic       overheated,
  output logic [7:0] shots_fired,
  output logic       fire_drop
);

  typedef enum logic [1:0] {IDLE, REQ, GAP, LOCK} state_t;

  localparam logic [3:0]       HMAX     = 4'(HEAT_MAX);
  localparam logic [3:0]       HRES     = 4'(HEAT_RESUME);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(FIRE_GAP - 1);

  state_t           state_q, state_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [7:0]       fire_x_q, fire_x_d;
  logic [7:0]       shots_q, shots_d;

`ifdef GUN_TIMEOUT_EN
  localparam int           TO_W    = $clog2(REQ_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(REQ_TIMEOUT - 1);
  logic [TO_W-1:0] tcnt_q, tcnt_d;
  logic            drop_q, drop_d;
`endif

  always_comb begin
    state_d  = state_q;
    gap_d    = gap_q;
    fire_x_d = fire_x_q;
    shots_d  = shots_q;
`ifdef GUN_TIMEOUT_EN
    drop_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        // Overheat check wins over a simultaneous trigger.
        if (heat >= HMAX) begin
          state_d = LOCK;
        end else if (trigger) begin
          state_d  = REQ;
          fire_x_d = ship_x;
        end
      end
      REQ: begin
        if (fire_ack) begin
          state_d = GAP;
          gap_d   = GAP_LOAD;
          if (shots_q != 8'hFF) shots_d = shots_q + 8'd1;
`ifdef GUN_TIMEOUT_EN
        end else if (tcnt_q == TO_LAST) begin
          state_d = GAP;
          gap_d   = GAP_LOAD;
          drop_d  = 1'b1;
`endif
        end
      end
      GAP: begin
        if (gap_q == '0) begin
          state_d = (heat >= HMAX) ? LOCK : IDLE;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      LOCK: begin
        if (heat <= HRES) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef GUN_TIMEOUT_EN
  always_comb begin
    tcnt_d = '0;
    if (state_q == REQ && state_d == REQ) tcnt_d = tcnt_q + 1'b1;
  end
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      gap_q    <= '0;
      fire_x_q <= '0;
      shots_q  <= '0;
`ifdef GUN_TIMEOUT_EN
      tcnt_q   <= '0;
      drop_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      gap_q    <= gap_d;
      fire_x_q <= fire_x_d;
      shots_q  <= shots_d;
`ifdef GUN_TIMEOUT_EN
      tcnt_q   <= tcnt_d;
      drop_q   <= drop_d;
`endif
    end
  end

  assign fire_req    = (state_q == REQ);
  assign overheated  = (state_q == LOCK);
  assign fire_x      = fire_x_q;
  assign shots_fired = shots_q;
`ifdef GUN_TIMEOUT_EN
  assign fire_drop   = drop_q;
`else
  assign fire_drop   = 1'b0;
`endif

endmodule

// File: tb/tb_gun_fire_controller.sv
// Directed bench for gun_fire_controller with FIRE_GAP=4 (and REQ_TIMEOUT=8 when enabled).
module tb_gun_fire_controller;

  logic       clock = 1'b0;
  logic       resetn;
  logic       trigger;
  logic [3:0] heat;
  logic [7:0] ship_x;
  logic       fire_ack;
  logic       fire_req;
  logic [7:0] fire_x;
  logic       overheated;
  logic [7:0] shots_fired;
  logic       fire_drop;

  int tests = 0;
  int fails = 0;

  gun_fire_controller #(
    .HEAT_MAX(15), .HEAT_RESUME(8), .FIRE_GAP(4), .GAP_W(4)
`ifdef GUN_TIMEOUT_EN
    , .REQ_TIMEOUT(8)
`endif
  ) dut (
    .clock(clock), .resetn(resetn), .trigger(trigger), .heat(heat),
    .ship_x(ship_x), .fire_ack(fire_ack), .fire_req(fire_req), .fire_x(fire_x),
    .overheated(overheated), .shots_fired(shots_fired), .fire_drop(fire_drop)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; trigger = 1'b1; heat = 4'd0; ship_x = 8'h00; fire_ack = 1'b0;
    repeat (3) tick();
    tests++;
    if (fire_req !== 1'b0 || overheated !== 1'b0 || shots_fired !== 8'd0 || fire_drop !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: req=%b ovh=%b shots=%0d drop=%b, required 0 0 0 0",
               fire_req, overheated, shots_fired, fire_drop);
    end
    trigger = 1'b0;
    resetn  = 1'b1;
    tick();
    tests++;
    if (fire_req !== 1'b0 || overheated !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle: req=%b ovh=%b, required 0 0", fire_req, overheated);
    end
  endtask

  task automatic test_single_shot();
    ship_x = 8'h3C; trigger = 1'b1;
    tick();
    trigger = 1'b0; ship_x = 8'h55;
    tests++;
    if (fire_req !== 1'b1 || fire_x !== 8'h3C) begin
      fails++;
      $display("FAIL single_req: req=%b x=%h, required 1 3c", fire_req, fire_x);
    end
    tick();
    tests++;
    if (fire_req !== 1'b1 || fire_x !== 8'h3C || shots_fired !== 8'd0) begin
      fails++;
      $display("FAIL single_hold: req=%b x=%h shots=%0d, required 1 3c 0", fire_req, fire_x, shots_fired);
    end
    fire_ack = 1'b1;
    tick();
    fire_ack = 1'b0;
    tests++;
    if (fire_req !== 1'b0 || shots_fired !== 8'd1) begin
      fails++;
      $display("FAIL single_ack: req=%b shots=%0d, required 0 1", fire_req, shots_fired);
    end
    // Ack during GAP must not count.
    fire_ack = 1'b1;
    repeat (4) tick();
    fire_ack = 1'b0;
    tests++;
    if (fire_req !== 1'b0 || shots_fired !== 8'd1) begin
      fails++;
      $display("FAIL ack_outside_req: req=%b shots=%0d, required 0 1", fire_req, shots_fired);
    end
  endtask

  task automatic test_auto_fire();
    int nreq = 0;
    int last = -1;
    int bad_gap = 0;
    trigger = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (fire_req === 1'b1) begin
        if (last >= 0 && i - last != 6) bad_gap++;
        last = i;
        nreq++;
      end
      fire_ack = fire_req;
    end
    trigger = 1'b0; fire_ack = 1'b0;
    tests++;
    if (nreq != 7 || bad_gap != 0) begin
      fails++;
      $display("FAIL auto_spacing: reqs=%0d bad_gaps=%0d, required 7 0", nreq, bad_gap);
    end
    tests++;
    if (shots_fired !== 8'd8) begin
      fails++;
      $display("FAIL auto_count: shots=%0d, required 8", shots_fired);
    end
    repeat (6) tick();
  endtask

  task automatic test_lockout();
    heat = 4'd14;
    tick();
    tests++;
    if (overheated !== 1'b0) begin
      fails++;
      $display("FAIL lock_14: ovh=%b, required 0", overheated);
    end
    heat = 4'd15; trigger = 1'b1;
    tick();
    tests++;
    if (overheated !== 1'b1 || fire_req !== 1'b0) begin
      fails++;
      $display("FAIL lock_enter: ovh=%b req=%b, required 1 0", overheated, fire_req);
    end
    heat = 4'd9;
    repeat (3) tick();
    tests++;
    if (overheated !== 1'b1 || fire_req !== 1'b0) begin
      fails++;
      $display("FAIL lock_hyst9: ovh=%b req=%b, required 1 0", overheated, fire_req);
    end
    heat = 4'd8;
    tick();
    tests++;
    if (overheated !== 1'b0 || fire_req !== 1'b0) begin
      fails++;
      $display("FAIL lock_release: ovh=%b req=%b, required 0 0", overheated, fire_req);
    end
    tick();
    tests++;
    if (fire_req !== 1'b1) begin
      fails++;
      $display("FAIL lock_refire: req=%b, required 1", fire_req);
    end
    trigger = 1'b0; fire_ack = 1'b1;
    tick();
    fire_ack = 1'b0;
    tests++;
    if (shots_fired !== 8'd9) begin
      fails++;
      $display("FAIL lock_shot: shots=%0d, required 9", shots_fired);
    end
    repeat (5) tick();
  endtask

  task automatic test_overheat_during_req();
    heat = 4'd0; trigger = 1'b1;
    tick();
    trigger = 1'b0; heat = 4'd15;
    tick();
    tests++;
    if (fire_req !== 1'b1 || overheated !== 1'b0) begin
      fails++;
      $display("FAIL ovr_pending: req=%b ovh=%b, required 1 0", fire_req, overheated);
    end
    fire_ack = 1'b1;
    tick();
    fire_ack = 1'b0;
    tests++;
    if (fire_req !== 1'b0 || shots_fired !== 8'd10) begin
      fails++;
      $display("FAIL ovr_ack: req=%b shots=%0d, required 0 10", fire_req, shots_fired);
    end
    repeat (3) tick();
    tests++;
    if (overheated !== 1'b0) begin
      fails++;
      $display("FAIL ovr_gap: ovh=%b, required 0", overheated);
    end
    tick();
    tests++;
    if (overheated !== 1'b1) begin
      fails++;
      $display("FAIL ovr_lock: ovh=%b, required 1", overheated);
    end
    heat = 4'd0;
    tick();
  endtask

  task automatic test_reset_mid_req();
    trigger = 1'b1;
    tick();
    trigger = 1'b0; fire_ack = 1'b1;
    #2 resetn = 1'b0;
    #1;
    tests++;
    if (fire_req !== 1'b0 || shots_fired !== 8'd0) begin
      fails++;
      $display("FAIL reset_mid_req: req=%b shots=%0d, required 0 0", fire_req, shots_fired);
    end
    tick();
    fire_ack = 1'b0; resetn = 1'b1;
    tick();
  endtask

  task automatic test_timeout();
    int hi = 0;
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
`ifdef GUN_TIMEOUT_EN
    for (int i = 0; i < 7; i++) begin
      tick();
      if (fire_req === 1'b1 && fire_drop === 1'b0) hi++;
    end
    tests++;
    if (hi != 7) begin
      fails++;
      $display("FAIL to_hold: cycles_held=%0d, required 7", hi);
    end
    tick();
    tests++;
    if (fire_req !== 1'b0 || fire_drop !== 1'b1 || shots_fired !== 8'd0) begin
      fails++;
      $display("FAIL to_drop: req=%b drop=%b shots=%0d, required 0 1 0", fire_req, fire_drop, shots_fired);
    end
    tick();
    tests++;
    if (fire_drop !== 1'b0) begin
      fails++;
      $display("FAIL to_pulse: drop=%b, required 0", fire_drop);
    end
    repeat (4) tick();
    // Ack on the timeout cycle counts as a shot.
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    repeat (7) tick();
    fire_ack = 1'b1;
    tick();
    fire_ack = 1'b0;
    tests++;
    if (fire_req !== 1'b0 || fire_drop !== 1'b0 || shots_fired !== 8'd1) begin
      fails++;
      $display("FAIL to_ack_wins: req=%b drop=%b shots=%0d, required 0 0 1", fire_req, fire_drop, shots_fired);
    end
`else
    for (int i = 0; i < 20; i++) begin
      tick();
      if (fire_req === 1'b1 && fire_drop === 1'b0) hi++;
    end
    tests++;
    if (hi != 20) begin
      fails++;
      $display("FAIL no_timeout_hold: cycles_held=%0d, required 20", hi);
    end
    fire_ack = 1'b1;
    tick();
    fire_ack = 1'b0;
    tests++;
    if (fire_req !== 1'b0 || shots_fired !== 8'd1) begin
      fails++;
      $display("FAIL no_timeout_ack: req=%b shots=%0d, required 0 1", fire_req, shots_fired);
    end
`endif
    repeat (5) tick();
  endtask

  task automatic test_saturation();
    int nreq = 0;
    int cyc = 0;
    trigger = 1'b1;
    while (nreq < 256 && cyc < 3000) begin
      tick();
      cyc++;
      if (fire_req === 1'b1) nreq++;
      fire_ack = fire_req;
    end
    tick();
    trigger = 1'b0; fire_ack = 1'b0;
    tests++;
    if (nreq != 256) begin
      fails++;
      $display("FAIL sat_budget: reqs=%0d in %0d cycles, required 256", nreq, cyc);
    end
    tests++;
    if (shots_fired !== 8'd255) begin
      fails++;
      $display("FAIL sat_count: shots=%0d, required 255", shots_fired);
    end
  endtask

  initial begin
    test_reset();
    test_single_shot();
    test_auto_fire();
    test_lockout();
    test_overheat_during_req();
    test_reset_mid_req();
    test_timeout();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
